// File: rtl/divider_with_memory.sv
// divider_with_memory
// Restoring divider fed from two fixed ROMs. The dividend (8b) and divisor (4b)
// are selected by addresses captured on the start edge; one quotient bit is
// resolved per clock, MSB first. Results are registered and held until the
// next result. A zero divisor short-circuits straight from LOAD to DONE with
// all-ones quotient/remainder and div_by_zero set.
//
// state | meaning
// IDLE  | waiting for start; addresses captured on the start edge
// LOAD  | ROM words latched into N/D, R/Q cleared, divisor-zero check
// DIV   | one restoring step per cycle, bit index counts 7 down to 0
// DONE  | one-cycle done pulse, results already on the outputs

module divider_with_memory (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] addr1,
  input  logic [2:0] addr2,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [2:0] a1_q, a1_d;
  logic [2:0] a2_q, a2_d;
  logic [7:0] n_q, n_d;
  logic [3:0] d_q, d_d;
  logic [4:0] r_q, r_d;
  logic [7:0] qacc_q, qacc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] rom_n;
  logic [3:0] rom_d;
  logic [4:0] r_shift;
  logic [4:0] r_sub;
  logic       r_ge;
  logic [4:0] r_iter;
  logic [7:0] q_iter;

  // Dividend ROM, indexed by the captured dividend address
  always_comb begin
    rom_n = 8'd0;
    case (a1_q)
      3'd0: rom_n = 8'd0;
      3'd1: rom_n = 8'd72;
      3'd2: rom_n = 8'd56;
      3'd3: rom_n = 8'd255;
      3'd4: rom_n = 8'd100;
      3'd5: rom_n = 8'd13;
      3'd6: rom_n = 8'd200;
      3'd7: rom_n = 8'd1;
      default: rom_n = 8'd0;
    endcase
  end

  // Divisor ROM, indexed by the captured divisor address
  always_comb begin
    rom_d = 4'd0;
    case (a2_q)
      3'd0: rom_d = 4'd0;
      3'd1: rom_d = 4'd12;
      3'd2: rom_d = 4'd6;
      3'd3: rom_d = 4'd7;
      3'd4: rom_d = 4'd8;
      3'd5: rom_d = 4'd1;
      3'd6: rom_d = 4'd15;
      3'd7: rom_d = 4'd3;
      default: rom_d = 4'd0;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // R < D <= 15 before the shift, so the 5-bit partial remainder never overflows.
  always_comb begin
    r_shift        = {r_q[3:0], n_q[cnt_q]};
    r_ge           = (r_shift >= {1'b0, d_q});
    r_sub          = r_shift - {1'b0, d_q};
    r_iter         = r_ge ? r_sub : r_shift;
    q_iter         = qacc_q;
    q_iter[cnt_q]  = r_ge;
  end

  // Sequencing and next-state for datapath and result registers
  always_comb begin
    state_d = state_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    n_d     = n_q;
    d_d     = d_q;
    r_d     = r_q;
    qacc_d  = qacc_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a1_d    = addr1;
          a2_d    = addr2;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end

      LOAD: begin
        n_d    = rom_n;
        d_d    = rom_d;
        r_d    = 5'd0;
        qacc_d = 8'd0;
        if (rom_d == 4'd0) begin
          quot_d  = 8'hFF;
          rem_d   = 4'hF;
          dbz_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = 3'd7;
          state_d = DIV;
        end
      end

      DIV: begin
        r_d    = r_iter;
        qacc_d = q_iter;
        if (cnt_q == 3'd0) begin
          quot_d  = q_iter;
          rem_d   = r_iter[3:0];
          dbz_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a1_q    <= 3'd0;
      a2_q    <= 3'd0;
      n_q     <= 8'd0;
      d_q     <= 4'd0;
      r_q     <= 5'd0;
      qacc_q  <= 8'd0;
      cnt_q   <= 3'd0;
      quot_q  <= 8'd0;
      rem_q   <= 4'd0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      n_q     <= n_d;
      d_q     <= d_d;
      r_q     <= r_d;
      qacc_q  <= qacc_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_divider_with_memory.sv
// Self-checking bench for divider_with_memory: directed cases plus random
// address pairs, compared against plain integer division of the ROM words.

module tb_divider_with_memory;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] addr1;
  logic [2:0] addr2;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  int dvd_rom [8] = '{0, 72, 56, 255, 100, 13, 200, 1};
  int dvs_rom [8] = '{0, 12, 6, 7, 8, 1, 15, 3};

  divider_with_memory dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .addr1       (addr1),
    .addr2       (addr2),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: integer division of the selected ROM words
  task automatic ref_div(input int a1, input int a2,
                         output int eq, output int er, output int ez, output int elat);
    int n, d;
    n = dvd_rom[a1];
    d = dvs_rom[a2];
    if (d == 0) begin
      eq = 255; er = 15; ez = 1; elat = 1;
    end else begin
      eq = n / d; er = n % d; ez = 0; elat = 9;
    end
  endtask

  // One full operation, from the negedge before the start edge to the done pulse.
  task automatic do_div(input int a1, input int a2, input bit scramble, input bit extra_start);
    int eq, er, ez, elat;
    int k, busy_cnt, done_cnt;
    int held_q, held_r, held_z;
    ref_div(a1, a2, eq, er, ez, elat);
    held_q = quotient; held_r = remainder; held_z = div_by_zero;
    @(negedge clk);
    addr1 = 3'(a1); addr2 = 3'(a2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; busy_cnt = 0;
    while (!done && k < 20) begin
      if (busy) busy_cnt++;
      if (k == 1 && scramble) begin addr1 = 3'd0; addr2 = 3'd0; end
      if (k == 2 && extra_start) start = 1'b1;
      if (k == 3) start = 1'b0;
      if (k == 0 && elat == 9) begin
        check("hold_q", quotient, held_q);
        check("hold_r", remainder, held_r);
        check("hold_z", div_by_zero, held_z);
      end
      @(negedge clk);
      k++;
    end
    check("latency", k, elat);
    check("busy_cycles", busy_cnt, elat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, ez);
    check("busy_in_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    if (extra_start) begin
      done_cnt = 0;
      for (int i = 0; i < 14; i++) begin
        if (done) done_cnt++;
        @(negedge clk);
      end
      check("ignored_start_dones", done_cnt, 0);
      check("ignored_start_busy", busy, 0);
    end
  endtask

  initial begin
    int eq, er, ez, elat, k, t_prev, pulses;
    rst = 1'b1; start = 1'b0; addr1 = 3'd0; addr2 = 3'd0;
    #2 rst = 1'b0;
    #1;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_div(1, 1, 1'b0, 1'b0);
    do_div(6, 6, 1'b0, 1'b0);
    do_div(5, 7, 1'b0, 1'b0);
    do_div(3, 5, 1'b0, 1'b0);
    do_div(4, 2, 1'b1, 1'b1);
    do_div(2, 0, 1'b0, 1'b0);
    do_div(2, 3, 1'b0, 1'b0);

    // Asynchronous reset during the 4th DIV cycle
    @(negedge clk);
    addr1 = 3'd1; addr2 = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    k = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) k++;
      @(negedge clk);
    end
    check("post_rst_idle", k, 0);
    do_div(3, 6, 1'b0, 1'b0);

    // Random address pairs
    for (int i = 0; i < 30; i++) begin
      do_div(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'b0);
    end

    // start held high: periodic results
    ref_div(7, 7, eq, er, ez, elat);
    @(negedge clk);
    addr1 = 3'd7; addr2 = 3'd7; start = 1'b1;
    t_prev = -1; pulses = 0; k = 0;
    while (pulses < 4 && k < 100) begin
      @(negedge clk);
      k++;
      if (done) begin
        if (t_prev >= 0) check("held_start_spacing", k - t_prev, 11);
        check("held_start_q", quotient, eq);
        check("held_start_r", remainder, er);
        t_prev = k;
        pulses++;
      end
    end
    check("held_start_pulses", pulses, 4);
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divider_with_memory.md
# divider_with_memory

Sequential restoring divider that reads both operands from internal ROMs, the inverse of the team's multiplier-with-memory block. An 8-bit dividend is selected from an 8-entry dividend ROM and a 4-bit divisor from an 8-entry divisor ROM. One quotient bit is produced per clock, and the block returns an 8-bit quotient and a 4-bit remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic lab design and shares its address-driven interface.

## Interface
Parameters: none. ROM contents are fixed in RTL.
- Dividend ROM (8-bit): [0]=0, [1]=72, [2]=56, [3]=255, [4]=100, [5]=13, [6]=200, [7]=1
- Divisor ROM (4-bit): [0]=0, [1]=12, [2]=6, [3]=7, [4]=8, [5]=1, [6]=15, [7]=3

Ports:
- clk  in  1  single system clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a division; sampled only in IDLE
- addr1  in  3  dividend ROM index; captured on the start edge
- addr2  in  3  divisor ROM index; captured on the start edge
- quotient  out  8  result quotient, held until the next result
- remainder  out  4  result remainder, held until the next result
- div_by_zero  out  1  set with the result when the divisor was 0, held with the result
- busy  out  1  high in LOAD and DIV
- done  out  1  one-cycle pulse in DONE

## Operation
- States are IDLE, LOAD, DIV and DONE.
- **IDLE:** when start=1 at a rising edge, register addr1/addr2 and go to LOAD. Otherwise stay.
- **LOAD:** read both ROMs combinationally from the registered addresses and latch them into N (8b) and D (4b). Clear R (5b) and Q (8b).
  - If D==0, go to DONE with quotient=8'hFF, remainder=4'hF, div_by_zero=1.
  - Otherwise load the bit counter with 7 and go to DIV.
- **DIV:** one iteration per cycle, for bit i = counter.
  - R' = {R[3:0], N[i]}.
  - If R' >= {1'b0, D}, then R = R' - D and Q[i] = 1. Otherwise R = R' and Q[i] = 0.
  - After i == 0, go to DONE and load quotient=Q, remainder=R[3:0], div_by_zero=0.
- **DONE:** done=1 for exactly one cycle, then go to IDLE unconditionally.
- Width rules:
  - R is 5 bits. Before the shift R < D <= 15, so R' <= 31 and nothing overflows.
  - The final R[4] is always 0.
- start is ignored outside IDLE. addr1/addr2 changes after the start edge have no effect on the operation in flight.
- If start is held high continuously, a new operation begins on the edge after DONE (IDLE samples it). Back-to-back throughput is one result per 11 cycles.
- The result outputs (quotient, remainder, div_by_zero) change only on the DONE entry edge.

## Timing
- **Reset:** rst=0 forces the following immediately, independent of clk, including mid-operation. The in-flight result is discarded.
  - state=IDLE
  - quotient=0, remainder=0, div_by_zero=0
  - busy=0, done=0
  - internal N/D/R/Q/counter=0
- **Normal latency:** call the start-sampling edge E0.
  - LOAD during cycle E0→E1.
  - DIV for cycles E1→E9 (8 cycles).
  - done=1 and results valid during E9→E10, then IDLE.
  - So done rises 9 edges after E0.
- **Divide-by-zero latency:** LOAD at E0→E1, done=1 during E1→E2, results valid from E1.
- busy=1 from E0 until the DONE entry edge. busy=0 in DONE and IDLE.
- All outputs are registered. There is no combinational path from start or addr to any output.

## Test plan
- Reset asserted, then released. Pulse start with addr1=1, addr2=1 (72/12) → done pulses 9 edges after start; quotient=6, remainder=0, div_by_zero=0, busy high for 9 cycles.
- addr1=6, addr2=6 (200/15) → quotient=13, remainder=5. Then addr1=5, addr2=7 (13/3) → quotient=4, remainder=1. Then addr1=3, addr2=5 (255/1) → quotient=255, remainder=0.
- addr1=4, addr2=2 (100/6) → quotient=16, remainder=4. Change addr1/addr2 to 0 during DIV → the result is unaffected. A start pulse during busy is ignored: exactly one done is produced.
- addr1=2, addr2=0 (56/0) → done 1 edge after LOAD; quotient=8'hFF, remainder=4'hF, div_by_zero=1. The next valid division (addr1=2, addr2=3, 56/7) clears div_by_zero and gives quotient=8, remainder=0.
- Start 72/12, then drive rst=0 mid-DIV at the 4th DIV cycle → all outputs 0 immediately. After release, no done appears until a new start; a new 255/15 (addr1=3, addr2=6) gives quotient=17, remainder=0.
- start held high with addr1=7, addr2=7 (1/3) → repeated done pulses spaced 11 cycles apart, each with quotient=0, remainder=1.
